play_scheduler: RTL and testbench
=================================

Name: play_scheduler

Overview:
- Sequences audio playback in the audioport control path.
- Generates the per-sample schedule: FIFO pop request, then DSP sample tick, at a programmable clk-cycles-per-sample rate (nominal CLK_DIV_48000).
- Tracks play/nodata status and raises a FIFO-refill interrupt.
- Sits between the APB register block (command decode, FIFO level) and the audio FIFOs / dsp_unit.

Parameters:
- FIFO_SIZE, AUDIO_FIFO_SIZE (60): FIFO depth in stereo sample pairs.
- IRQ_THRESHOLD, FIFO_SIZE/2 (30): irq fires when level at a sample event is <= this value.
- MIN_DIV, 2: smallest accepted clk_div; smaller values are clamped up to it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_in  in  1  CMD_START pulse (one cycle)
- stop_in  in  1  CMD_STOP pulse
- clr_in  in  1  CMD_CLR pulse
- irqack_in  in  1  CMD_IRQACK pulse
- clk_div_in  in  32  clk cycles per sample; sampled only when start is accepted
- fifo_level_in  in  7  occupancy of the FIFO pair, 0..FIFO_SIZE
- fifo_pop_out  out  1  pop one left/right pair, one-cycle pulse
- tick_out  out  1  sample strobe to dsp_unit, one-cycle pulse
- play_out  out  1  STATUS_PLAY bit
- nodata_out  out  1  STATUS_NODATA bit, sticky
- irq_out  out  1  interrupt request, level, held until acknowledged

Behaviour:
- Reset (async, rst=1): state IDLE, div_r=0, cnt=0, irq_armed=1. All outputs 0.
- All outputs are registered.
- State IDLE:
  - start_in=1 and stop_in=0 -> PLAY next cycle.
  - On acceptance: div_r <= max(clk_div_in, MIN_DIV); cnt <= that value - 1; nodata_out <= 0.
  - clr_in=1 -> nodata_out <= 0, irq_out <= 0, irq_armed <= 1.
- State PLAY:
  - play_out=1.
  - cnt decrements each cycle. When cnt==0, this is a sample event: cnt reloads div_r-1.
  - If start is accepted at cycle T, the first event is at cycle T+div_r, and events repeat every div_r cycles.
- Sample event at cycle E:
  - If fifo_level_in != 0: fifo_pop_out=1 at E+1.
  - If fifo_level_in == 0: no pop; nodata_out <= 1 at E+1 and stays until the next accepted start or clr_in in IDLE.
  - tick_out=1 at E+2 in both cases; dsp_unit consumes FIFO read data, or zero when nodata.
- Interrupt:
  - Set condition: sample event with fifo_level_in <= IRQ_THRESHOLD and irq_armed=1. Then irq_out <= 1 and irq_armed <= 0 at E+1.
  - irqack_in: irq_out <= 0, irq_armed <= 1, in any state.
  - irqack_in in the same cycle as a set condition: ack wins; the set is re-evaluated at the next event.
- stop_in in PLAY -> IDLE next cycle; play_out=0; cnt is held.
  - An already-issued pop still gets its tick at E+2, even if stop arrives between E and E+2.
  - No further events after the stop.
- Priorities and ignored inputs:
  - start_in and stop_in in the same cycle: stop wins, start is ignored.
  - start_in in PLAY is ignored; div_r does not change mid-play.
  - clr_in in PLAY is ignored.
- Clamping: clk_div_in of 0 or 1 is treated as 2. With div_r=2, consecutive pops are 2 cycles apart; pop and tick pipelines may overlap and must both be honoured.
- Level/pop consistency: the level is at most one cycle stale w.r.t. the pop. Because div_r >= 2, the level is always updated before the next event.
- Reset mid-play: immediate return to IDLE; any pending pop/tick is discarded.

Decomposition:
- audioport_pkg: FIFO_SIZE (AUDIO_FIFO_SIZE), CLK_DIV_48000, new IRQ_THRESHOLD constant, MIN_DIV, and typedef enum logic {IDLE, PLAY} play_state_t.
- One natural sub-module: sample_tick_divider.
  - Contains the loadable down-counter (div_r, cnt).
  - Inputs: enable, load.
  - Output: event pulse.
- play_scheduler holds the FSM, the pop/tick pipeline, and the status/irq logic.

Test Plan:
- Basic cadence: clk_div_in=8, level=40, start at cycle 10 -> pop at 19, 27, 35...; tick at 20, 28, 36...; play_out=1 from cycle 11; irq_out stays 0.
- Nodata: level=0, clk_div_in=8, start -> no pop; tick still pulses; nodata_out=1 after first event. A second start clears it; clr_in in IDLE clears it.
- Interrupt: level stepped 32, 31, 30, 29 across events -> irq_out rises the cycle after the level=30 event and stays high. irqack pulse -> irq_out=0. Next event at level 28 re-raises it. Ack in the same cycle as a set -> irq_out stays 0 until the next event.
- Stop/start corner cases:
  - start+stop same cycle -> stays IDLE.
  - stop one cycle after an event -> the tick for that event still appears; no further pops.
  - start in PLAY with clk_div_in=4 -> cadence remains 8.
- Clamping: clk_div_in=0 and 1 -> events every 2 cycles, back-to-back pop/tick overlap correct.
- Async reset asserted between pop and tick -> all outputs 0 immediately; no tick after reset release; state IDLE.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared constants and types for the audioport control path.
// Play scheduler state encoding and FIFO/irq sizing live here.
package audioport_pkg;

  localparam int AUDIO_FIFO_SIZE = 60;
  localparam int FIFO_SIZE = AUDIO_FIFO_SIZE;
  // Nominal divider for a 48 kHz sample rate from a 100 MHz system clock.
  localparam logic [31:0] CLK_DIV_48000 = 32'd2083;
  localparam int IRQ_THRESHOLD = FIFO_SIZE / 2;
  localparam logic [31:0] MIN_DIV = 32'd2;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } play_state_t;

endpackage

// File: rtl/sample_tick_divider.sv
// Loadable down-counter that marks one sample event every div_r cycles.
// event_out is combinational; the scheduler registers everything derived from it.
module sample_tick_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] div_in,
  output logic        event_out
);

  logic [31:0] r_div;
  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_div <= div_in;
      r_cnt <= div_in - 32'd1;
    end else if (enable) begin
      if (r_cnt == '0) r_cnt <= r_div - 32'd1;
      else             r_cnt <= r_cnt - 32'd1;
    end
  end

  assign event_out = enable && (r_cnt == '0);

endmodule

// File: rtl/play_scheduler.sv
// Playback sequencer: per-sample FIFO pop then DSP tick, play/nodata status
// and a FIFO-refill interrupt. All outputs come straight from flops.
module play_scheduler
  import audioport_pkg::*;
#(
  parameter int          FIFO_SIZE     = audioport_pkg::FIFO_SIZE,
  parameter int          IRQ_THRESHOLD = FIFO_SIZE / 2,
  parameter logic [31:0] MIN_DIV       = audioport_pkg::MIN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        clr_in,
  input  logic        irqack_in,
  input  logic [31:0] clk_div_in,
  input  logic [6:0]  fifo_level_in,
  output logic        fifo_pop_out,
  output logic        tick_out,
  output logic        play_out,
  output logic        nodata_out,
  output logic        irq_out,
  output play_state_t state_out
);

  localparam logic [6:0] THRESH = 7'(IRQ_THRESHOLD);

  play_state_t r_state;
  logic        r_play, r_pop, r_tick_pend, r_tick, r_nodata, r_irq, r_irq_armed;
  logic        w_accept, w_enable, w_event, w_level_zero, w_level_low;
  logic [31:0] w_div;

  // Stop beats start, and a stop cycle never produces a new sample event.
  assign w_accept     = (r_state == IDLE) && start_in && !stop_in;
  assign w_enable     = (r_state == PLAY) && !stop_in;
  assign w_div        = (clk_div_in < MIN_DIV) ? MIN_DIV : clk_div_in;
  assign w_level_zero = (fifo_level_in == '0);
  assign w_level_low  = (fifo_level_in <= THRESH);

  sample_tick_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept),
    .enable    (w_enable),
    .div_in    (w_div),
    .event_out (w_event)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_play      <= 1'b0;
      r_pop       <= 1'b0;
      r_tick_pend <= 1'b0;
      r_tick      <= 1'b0;
      r_nodata    <= 1'b0;
      r_irq       <= 1'b0;
      r_irq_armed <= 1'b1;
    end else begin
      // Pop/tick pipeline keeps running across a stop so an issued pop gets its tick.
      r_pop       <= w_event && !w_level_zero;
      r_tick_pend <= w_event;
      r_tick      <= r_tick_pend;
      if (w_event && w_level_zero) r_nodata <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= PLAY;
            r_play   <= 1'b1;
            r_nodata <= 1'b0;
          end
          if (clr_in) begin
            r_nodata    <= 1'b0;
            r_irq       <= 1'b0;
            r_irq_armed <= 1'b1;
          end
        end
        PLAY: begin
          if (stop_in) begin
            r_state <= IDLE;
            r_play  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Ack wins over a same-cycle set; the set is retried at the next event.
      if (irqack_in) begin
        r_irq       <= 1'b0;
        r_irq_armed <= 1'b1;
      end else if (w_event && w_level_low && r_irq_armed) begin
        r_irq       <= 1'b1;
        r_irq_armed <= 1'b0;
      end
    end
  end

  assign fifo_pop_out = r_pop;
  assign tick_out     = r_tick;
  assign play_out     = r_play;
  assign nodata_out   = r_nodata;
  assign irq_out      = r_irq;
  assign state_out    = r_state;

endmodule

// File: tb/tb_play_scheduler.sv
// Directed bench for play_scheduler: cadence, nodata, irq, stop/start corners,
// divider clamping and asynchronous reset, all against hand-computed cycles.
module tb_play_scheduler;
  import audioport_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in, stop_in, clr_in, irqack_in;
  logic [31:0] clk_div_in;
  logic [6:0]  fifo_level_in;
  logic        fifo_pop_out, tick_out, play_out, nodata_out, irq_out;
  play_state_t state_out;

  int          cyc = 0;
  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic        any_pop;
  logic [1:0]  exp_q[$];
  logic [1:0]  exp_v;

  play_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .clr_in        (clr_in),
    .irqack_in     (irqack_in),
    .clk_div_in    (clk_div_in),
    .fifo_level_in (fifo_level_in),
    .fifo_pop_out  (fifo_pop_out),
    .tick_out      (tick_out),
    .play_out      (play_out),
    .nodata_out    (nodata_out),
    .irq_out       (irq_out),
    .state_out     (state_out)
  );

  // clock / cycle index: cyc is the number of rising edges seen so far
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"},    32'(fifo_pop_out), 32'd0);
    check({tag, "_tick"},   32'(tick_out),     32'd0);
    check({tag, "_play"},   32'(play_out),     32'd0);
    check({tag, "_nodata"}, 32'(nodata_out),   32'd0);
    check({tag, "_irq"},    32'(irq_out),      32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_in = 1'b0; stop_in = 1'b0; clr_in = 1'b0; irqack_in = 1'b0;
    clk_div_in = 32'd8; fifo_level_in = 7'd40;

    // reset state
    goto(2);
    check_all_zero("rst");
    check("rst_state", 32'(state_out), 32'(IDLE));
    rst = 1'b0;
    goto(3);
    check_all_zero("post_rst");

    // basic cadence, div 8, start at 10
    goto(10);
    check("cad_play_pre", 32'(play_out), 32'd0);
    start_in = 1'b1; clk_div_in = 32'd8;
    goto(11); start_in = 1'b0;
    check("cad_play", 32'(play_out), 32'd1);
    check("cad_state", 32'(state_out), 32'(PLAY));
    goto(18); check("cad_pop18", 32'(fifo_pop_out), 32'd0);
    goto(19); check("cad_pop19", 32'(fifo_pop_out), 32'd1);
    check("cad_tick19", 32'(tick_out), 32'd0);
    goto(20); check("cad_tick20", 32'(tick_out), 32'd1);
    check("cad_pop20", 32'(fifo_pop_out), 32'd0);
    goto(27); check("cad_pop27", 32'(fifo_pop_out), 32'd1);
    goto(28); check("cad_tick28", 32'(tick_out), 32'd1);
    check("cad_irq", 32'(irq_out), 32'd0);

    // start in PLAY with div 4 is ignored
    goto(30); start_in = 1'b1; clk_div_in = 32'd4;
    goto(31); start_in = 1'b0;
    goto(35); check("ign_pop35", 32'(fifo_pop_out), 32'd1);
    goto(39); check("ign_pop39", 32'(fifo_pop_out), 32'd0);
    goto(43); check("ign_pop43", 32'(fifo_pop_out), 32'd1);

    // stop one cycle after the event at 42
    stop_in = 1'b1;
    goto(44); stop_in = 1'b0;
    check("stop_tick44", 32'(tick_out), 32'd1);
    check("stop_play44", 32'(play_out), 32'd0);
    any_pop = 1'b0;
    for (int c = 45; c <= 55; c++) begin
      goto(c);
      any_pop |= fifo_pop_out;
    end
    check("stop_nopop", 32'(any_pop), 32'd0);

    // nodata: level 0, start at 60, event at 68
    goto(60); fifo_level_in = 7'd0; start_in = 1'b1; clk_div_in = 32'd8;
    goto(61); start_in = 1'b0;
    goto(68); check("nd_nodata68", 32'(nodata_out), 32'd0);
    goto(69); check("nd_nodata69", 32'(nodata_out), 32'd1);
    check("nd_pop69", 32'(fifo_pop_out), 32'd0);
    check("nd_irq69", 32'(irq_out), 32'd1);
    goto(70); check("nd_tick70", 32'(tick_out), 32'd1);
    goto(72); stop_in = 1'b1;
    goto(73); stop_in = 1'b0;
    goto(74); irqack_in = 1'b1;
    goto(75); irqack_in = 1'b0;
    check("nd_ack_irq", 32'(irq_out), 32'd0);
    check("nd_sticky", 32'(nodata_out), 32'd1);
    goto(76); start_in = 1'b1;
    goto(77); start_in = 1'b0;
    check("nd_start_clr", 32'(nodata_out), 32'd0);
    goto(85); check("nd_again", 32'(nodata_out), 32'd1);
    check("nd_irq85", 32'(irq_out), 32'd1);
    goto(86); stop_in = 1'b1;
    goto(87); stop_in = 1'b0;
    check("nd_state87", 32'(state_out), 32'(IDLE));
    goto(89); clr_in = 1'b1;
    goto(90); clr_in = 1'b0;
    check("clr_nodata", 32'(nodata_out), 32'd0);
    check("clr_irq", 32'(irq_out), 32'd0);

    // interrupt threshold: events at 108,116,124,132,140,148,156
    goto(100); fifo_level_in = 7'd32; start_in = 1'b1; clk_div_in = 32'd8;
    goto(101); start_in = 1'b0;
    goto(110); fifo_level_in = 7'd31;
    goto(117); check("irq_31", 32'(irq_out), 32'd0);
    goto(118); fifo_level_in = 7'd30;
    goto(124); check("irq_pre30", 32'(irq_out), 32'd0);
    goto(125); check("irq_30", 32'(irq_out), 32'd1);
    goto(126); fifo_level_in = 7'd29;
    goto(133); check("irq_hold", 32'(irq_out), 32'd1);
    goto(134); irqack_in = 1'b1;
    goto(135); irqack_in = 1'b0;
    check("irq_ack", 32'(irq_out), 32'd0);
    fifo_level_in = 7'd28;
    goto(140); check("irq_pre28", 32'(irq_out), 32'd0);
    goto(141); check("irq_28", 32'(irq_out), 32'd1);
    goto(142); irqack_in = 1'b1;
    goto(143); irqack_in = 1'b0;
    check("irq_ack2", 32'(irq_out), 32'd0);
    goto(148); irqack_in = 1'b1;
    goto(149); irqack_in = 1'b0;
    check("irq_ack_wins", 32'(irq_out), 32'd0);
    goto(156); check("irq_pre_retry", 32'(irq_out), 32'd0);
    goto(157); check("irq_retry", 32'(irq_out), 32'd1);
    goto(158); stop_in = 1'b1;
    goto(159); stop_in = 1'b0;
    goto(160); irqack_in = 1'b1;
    goto(161); irqack_in = 1'b0;
    check("irq_cleanup", 32'(irq_out), 32'd0);

    // start and stop together stay IDLE
    goto(170); fifo_level_in = 7'd40; start_in = 1'b1; stop_in = 1'b1;
    goto(171); start_in = 1'b0; stop_in = 1'b0;
    check("ss_play", 32'(play_out), 32'd0);
    check("ss_state", 32'(state_out), 32'(IDLE));
    any_pop = 1'b0;
    for (int c = 172; c <= 185; c++) begin
      goto(c);
      any_pop |= fifo_pop_out;
    end
    check("ss_nopop", 32'(any_pop), 32'd0);

    // clamp div 0 -> 2: events 192..198, stop at 199; expected {pop,tick} per cycle
    for (int c = 191; c <= 204; c++) begin
      exp_v[1] = (c >= 193 && c <= 199 && (c % 2) == 1);
      exp_v[0] = (c >= 194 && c <= 200 && (c % 2) == 0);
      exp_q.push_back(exp_v);
    end
    goto(190); start_in = 1'b1; clk_div_in = 32'd0;
    for (int c = 191; c <= 204; c++) begin
      goto(c);
      start_in = 1'b0;
      exp_v = exp_q.pop_front();
      check($sformatf("clamp0_c%0d", c), {30'd0, fifo_pop_out, tick_out}, {30'd0, exp_v});
      stop_in = (c == 199);
    end
    stop_in = 1'b0;

    // clamp div 1 -> 2
    goto(210); start_in = 1'b1; clk_div_in = 32'd1;
    goto(211); start_in = 1'b0;
    goto(212); check("clamp1_pop212", 32'(fifo_pop_out), 32'd0);
    goto(213); check("clamp1_pop213", 32'(fifo_pop_out), 32'd1);
    goto(214); check("clamp1_tick214", 32'(tick_out), 32'd1);
    check("clamp1_pop214", 32'(fifo_pop_out), 32'd0);
    goto(215); check("clamp1_pop215", 32'(fifo_pop_out), 32'd1);
    check("clamp1_tick215", 32'(tick_out), 32'd0);
    goto(217); stop_in = 1'b1;
    goto(218); stop_in = 1'b0;
    check("clamp1_tick218", 32'(tick_out), 32'd1);
    check("clamp1_idle", 32'(state_out), 32'(IDLE));

    // async reset between pop (239) and tick (240)
    goto(230); start_in = 1'b1; clk_div_in = 32'd8;
    goto(231); start_in = 1'b0;
    goto(239); check("ar_pop", 32'(fifo_pop_out), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("ar_now");
    check("ar_state", 32'(state_out), 32'(IDLE));
    goto(240); rst = 1'b0;
    any_pop = 1'b0;
    for (int c = 240; c <= 245; c++) begin
      goto(c);
      any_pop |= tick_out | fifo_pop_out | play_out;
    end
    check("ar_no_tick", 32'(any_pop), 32'd0);
    check("ar_state_end", 32'(state_out), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
